pipelined_mux_tree: RTL and testbench
=====================================

Name: pipelined_mux_tree

Overview:
- Parametrised, pipelined successor to the 16:1 8-bit ALU result mux tree.
- Selects one of NUM_IN words of WIDTH bits. One register stage per 2:1 tree level; valid/ready handshake on both sides.
- Per-stage bubble collapsing, so the ALU result path closes timing at any width/depth and tolerates downstream stalls without losing data.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- SEL_W, 4, select width and number of tree levels/pipeline stages (>=1).
- NUM_IN, 2**SEL_W, input count. Derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream presents in_data/in_sel this cycle.
- in_ready  output  1  stage 0 accepts this cycle. Combinational from the stall chain.
- in_sel  input  SEL_W  select; value i picks word i.
- in_data  input  NUM_IN*WIDTH  flat input bus; word i = in_data[i*WIDTH +: WIDTH].
- out_valid  output  1  out_data/out_sel hold a valid result.
- out_ready  input  1  downstream consumes the result this cycle.
- out_data  output  WIDTH  selected word.
- out_sel  output  SEL_W  select value that produced out_data (echo for checking).
- busy  output  1  OR of all stage valid bits.

Behaviour:
- Tree structure: level k (0..SEL_W-1) reduces NUM_IN>>k words to NUM_IN>>(k+1) words using select bit k. Pair j outputs word 2j when the bit is 0, word 2j+1 when it is 1, so bit 0 resolves adjacent inputs first. The result equals in_data word in_sel.
- Stage k register holds:
  - v_k (valid);
  - NUM_IN>>(k+1) words;
  - the full original select, carried for out_sel.
- The last stage (k=SEL_W-1) holds one word and drives out_valid/out_data/out_sel directly from registers. There is no combinational path from in_data to out_data.
- Advance rule:
  - ready_last = out_ready; ready_k = load_{k+1} for k < SEL_W-1.
  - load_k = !v_k || ready_k.
  - in_ready = load_0.
- On load_k:
  - Stage 0 captures in_valid, the level-0 reduction of in_data, and in_sel.
  - Stage k>0 captures v_{k-1}, the level-k reduction of stage k-1 words, and the stage k-1 select.
  - When load_k is 0, stage k holds all contents.
- Transfers: input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
- Latency: exactly SEL_W cycles from input transfer to out_valid when out_ready stays 1. Throughput is 1 word/cycle.
- Bubbles: an empty stage always loads, so gaps in in_valid collapse under backpressure. With out_ready held 0, the pipeline accepts up to SEL_W words before in_ready drops.
- Stall stability: while out_valid && !out_ready, out_data and out_sel stay constant.
- Full pipeline, out_ready=1: simultaneous input and output transfers occur every cycle with no bubble and no loss.
- in_data/in_sel are don't-care when in_valid=0; a stage loaded with v=0 may capture garbage data, but out_valid stays 0.
- Ordering: results emerge in input order; nothing is dropped or duplicated.
- Reset (rst_n=0 at a clk edge), including mid-operation:
  - all v_k=0, all stage words=0, stored selects=0;
  - out_valid=0, out_data=0, out_sel=0, busy=0;
  - in-flight words are discarded.
- in_ready during reset follows the rule: 1 once v are cleared. Upstream must not count transfers while rst_n=0.
- SEL_W=1 degenerates to a registered 2:1 mux with a 1-deep handshake buffer.

Test Plan:
- Default params, in_data word i = 8'h10+i, in_sel swept 0..15 back-to-back, out_ready=1 -> out_valid first rises 4 cycles after the first transfer; out_data sequence 8'h10..8'h1F on consecutive cycles; out_sel matches; in_ready always 1.
- Inputs as above, sel=5 then sel=12, out_ready=0 from cycle 0 -> exactly 4 words accepted, then in_ready=0. out_data holds 8'h15 steady. Releasing out_ready yields the 4 words in order, one per cycle.
- Sparse input (one valid every 3 cycles), out_ready toggling 1/0 each cycle -> no loss or duplicate; every output matches the scoreboard; busy=0 after the last word drains.
- 3 words in flight, assert rst_n=0 for one cycle -> next cycle out_valid=0, out_data=8'h00, busy=0. A new word sel=3 then emerges 4 cycles after its transfer with 8'h13.
- WIDTH=32, SEL_W=2, words 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF with sel=2 -> out_data=32'h89ABCDEF after 2 cycles.
- SEL_W=1, WIDTH=1, sel alternating 0/1 with words 0/1 -> out_data toggles 0,1,... one cycle after input.

Source files
------------

// File: rtl/pipelined_mux_tree.sv
// Pipelined NUM_IN:1 word selector: one registered 2:1 reduction level per select bit,
// with a valid/ready handshake and per-stage bubble collapsing.
module pipelined_mux_tree #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SEL_W-1:0]                in_sel,
    input  logic [(WIDTH << SEL_W)-1:0]     in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [SEL_W-1:0]                out_sel,
    output logic                            busy
);

    localparam int NUM_IN = 1 << SEL_W;

    logic [SEL_W-1:0] v_all;
    logic [SEL_W-1:0] load;

    assign in_ready = load[0];
    assign busy     = |v_all;

    generate
        for (genvar gi = 0; gi < SEL_W; gi++) begin : gen_stage
            localparam int NW_IN  = NUM_IN >> gi;
            localparam int NW_OUT = NW_IN / 2;

            logic [NW_IN*WIDTH-1:0]  src_words;
            logic                    src_v;
            logic [SEL_W-1:0]        src_sel;
            logic [NW_OUT*WIDTH-1:0] red_words;
            logic [NW_OUT*WIDTH-1:0] words_reg;
            logic                    v_reg;
            logic [SEL_W-1:0]        sel_reg;

            if (gi == 0) begin : gen_src_in
                assign src_words = in_data;
                assign src_v     = in_valid;
                assign src_sel   = in_sel;
            end else begin : gen_src_prev
                assign src_words = gen_stage[gi-1].words_reg;
                assign src_v     = gen_stage[gi-1].v_reg;
                assign src_sel   = gen_stage[gi-1].sel_reg;
            end

            // Select bit gi picks between adjacent words, so bit 0 resolves first.
            for (genvar gj = 0; gj < NW_OUT; gj++) begin : gen_pair
                assign red_words[gj*WIDTH +: WIDTH] = src_sel[gi]
                    ? src_words[(2*gj+1)*WIDTH +: WIDTH]
                    : src_words[(2*gj)*WIDTH +: WIDTH];
            end

            // Unrolled stall chain: a stage may load unless it and every stage
            // after it are full while the consumer is stalled.
            assign load[gi] = out_ready | ~(&v_all[SEL_W-1:gi]);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_reg     <= 1'b0;
                    words_reg <= '0;
                    sel_reg   <= '0;
                end else if (load[gi]) begin
                    v_reg     <= src_v;
                    words_reg <= red_words;
                    sel_reg   <= src_sel;
                end
            end

            assign v_all[gi] = v_reg;

            if (gi == SEL_W - 1) begin : gen_out
                assign out_valid = v_reg;
                assign out_data  = words_reg;
                assign out_sel   = sel_reg;
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Directed bench for pipelined_mux_tree: default 16:1x8, a 4:1x32 and a 2:1x1 instance.
`timescale 1ns/1ps
module tb_pipelined_mux_tree;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default instance (WIDTH=8, SEL_W=4)
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]   in_sel, out_sel;
    logic [127:0] in_data;
    logic [7:0]   out_data;

    // WIDTH=32, SEL_W=2
    logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
    logic [1:0]   w_in_sel, w_out_sel;
    logic [127:0] w_in_data;
    logic [31:0]  w_out_data;

    // WIDTH=1, SEL_W=1
    logic         n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_busy;
    logic [0:0]   n_in_sel, n_out_sel;
    logic [1:0]   n_in_data;
    logic [0:0]   n_out_data;

    pipelined_mux_tree dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .busy(busy)
    );

    pipelined_mux_tree #(.WIDTH(32), .SEL_W(2)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_sel(w_in_sel), .in_data(w_in_data),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .out_sel(w_out_sel), .busy(w_busy)
    );

    pipelined_mux_tree #(.WIDTH(1), .SEL_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_sel(n_in_sel), .in_data(n_in_data),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .out_sel(n_out_sel), .busy(n_busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int got;
        logic [3:0] q[$];
        logic [3:0] e_sel;
        logic [3:0] sels2 [5];
        logic [3:0] acc2 [$];
        int idx;

        for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
        w_in_data = {32'hFFFFFFFF, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};
        n_in_data = 2'b10;
        rst_n = 1'b0;
        in_valid = 1'b0;  in_sel = '0;  out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_sel = '0; w_out_ready = 1'b1;
        n_in_valid = 1'b0; n_in_sel = '0; n_out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Back-to-back sweep, out_ready=1: 4-cycle latency, 1 word/cycle
        for (int i = 0; i < 20; i++) begin
            in_valid = (i < 16);
            in_sel   = 4'(i);
            #1;
            chk("sweep_in_ready", 32'(in_ready), 32'd1);
            tick();
            if (i >= 3 && i - 3 < 16) begin
                chk("sweep_out_valid", 32'(out_valid), 32'd1);
                chk("sweep_out_data", 32'(out_data), 32'h10 + 32'(i - 3));
                chk("sweep_out_sel", 32'(out_sel), 32'(i - 3));
            end else begin
                chk("sweep_out_idle", 32'(out_valid), 32'd0);
            end
        end
        in_valid = 1'b0;
        tick();

        // Backpressure from cycle 0: exactly 4 words accepted, output stable
        sels2[0] = 4'd5; sels2[1] = 4'd12; sels2[2] = 4'd7; sels2[3] = 4'd1; sels2[4] = 4'd9;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_sel   = sels2[idx];
            #1;
            if (in_ready) begin
                acc2.push_back(sels2[idx]);
                idx++;
            end
            tick();
        end
        chk("bp_accepted", 32'(idx), 32'd4);
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'(out_data), 32'h15);
            chk("bp_hold_sel", 32'(out_sel), 32'd5);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_drain_valid", 32'(out_valid), 32'd1);
            chk("bp_drain_data", 32'(out_data), 32'h10 + 32'(sels2[k]));
            tick();
        end
        chk("bp_drained_valid", 32'(out_valid), 32'd0);
        chk("bp_drained_busy", 32'(busy), 32'd0);

        // Sparse input with toggling out_ready, scoreboard check
        sent = 0;
        got  = 0;
        for (int c = 0; c < 150 && got < 10; c++) begin
            in_valid  = (c % 3 == 0) && (sent < 10);
            in_sel    = 4'((sent * 7 + 3) % 16);
            out_ready = (c % 2 == 1);
            #1;
            if (in_valid && in_ready) begin
                q.push_back(in_sel);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sparse_extra_output", 32'd1, 32'd0);
                end else begin
                    e_sel = q.pop_front();
                    chk("sparse_out_sel", 32'(out_sel), 32'(e_sel));
                    chk("sparse_out_data", 32'(out_data), 32'h10 + 32'(e_sel));
                end
                got++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("sparse_received", 32'(got), 32'd10);
        chk("sparse_queue_empty", 32'(q.size()), 32'd0);
        tick();
        chk("sparse_busy_idle", 32'(busy), 32'd0);

        // Mid-flight reset discards three in-flight words
        in_valid = 1'b1; in_sel = 4'd1; tick();
        in_sel = 4'd2; tick();
        in_sel = 4'd4; tick();
        in_valid = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_data", 32'(out_data), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_sel = 4'd3;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            chk("mrst_latency_idle", 32'(out_valid), 32'd0);
            tick();
        end
        chk("mrst_new_valid", 32'(out_valid), 32'd1);
        chk("mrst_new_data", 32'(out_data), 32'h13);
        chk("mrst_new_sel", 32'(out_sel), 32'd3);
        tick();

        // WIDTH=32, SEL_W=2: two-cycle latency
        w_in_valid = 1'b1; w_in_sel = 2'd2;
        tick();
        w_in_sel = 2'd1;
        tick();
        w_in_valid = 1'b0;
        chk("w32_sel2_valid", 32'(w_out_valid), 32'd1);
        chk("w32_sel2_data", w_out_data, 32'h89ABCDEF);
        tick();
        chk("w32_sel1_data", w_out_data, 32'h01234567);
        chk("w32_sel1_sel", 32'(w_out_sel), 32'd1);
        tick();
        chk("w32_idle", 32'(w_out_valid), 32'd0);

        // WIDTH=1, SEL_W=1: registered 2:1 mux, one-cycle latency
        chk("n1_idle", 32'(n_out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            n_in_valid = 1'b1;
            n_in_sel   = 1'(i % 2);
            tick();
            chk("n1_valid", 32'(n_out_valid), 32'd1);
            chk("n1_data", 32'(n_out_data), 32'(i % 2));
            chk("n1_sel", 32'(n_out_sel), 32'(i % 2));
        end
        n_in_valid = 1'b0;
        tick();
        chk("n1_drained", 32'(n_out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
